// File: rtl/i2c_pkg.sv
// Shared types and constants for the system-clocked I2C target with register file.
//
// Contents:
//   i2c_slv_state_e : protocol FSM states
//   I2C_ACK/I2C_NACK: SDA level of the acknowledge bit
//   I2C_RW_READ     : R/W bit value that selects a read transfer
//   drive_low()     : maps a bit to be placed on the bus onto the open-drain enable
`timescale 1ns/1ps

package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWr,
        StWrAck,
        StRd,
        StRdAck,
        StIgnore
    } i2c_slv_state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    // Open-drain: a '0' on the bus is produced by enabling the pull-down.
    function automatic logic drive_low(input logic b);
        return (b == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditioning for one I2C pad input sampled on the system clock.
//
// Two-flop synchroniser, optional 3-sample majority filter, then registered
// rise/fall detection. The level output is aligned with the edge pulses so the
// consumer sees a consistent snapshot of both lines.
//
// Optional feature: define I2C_SLAVE_GLITCH_FILTER_EN to insert the majority
// filter (suppresses pulses of one clock or less, adds 2 clk of latency).
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   line_i : raw pad input
//   lvl_o  : conditioned level
//   rise_o : one-cycle pulse on a conditioned 0->1 transition
//   fall_o : one-cycle pulse on a conditioned 1->0 transition
`timescale 1ns/1ps

module i2c_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q;
    logic cond_val;
    logic lvl_q, rise_q, fall_q;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], sync2_q};
        end
    end

    // Majority of the last three synchronised samples.
    assign cond_val = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                      (hist_q[1] & hist_q[2]);
`else
    assign cond_val = sync2_q;
`endif

    // Reset to the idle bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            lvl_q   <= cond_val;
            rise_q  <= cond_val & ~lvl_q;
            fall_q  <= ~cond_val & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// System-clocked I2C target with an internal register file, register pointer
// and auto-increment.
//
// Protocol: START, addr+W, pointer byte, then data bytes written at ptr with
// wrapping auto-increment; or START, addr+R, data bytes read from ptr. The
// pointer survives across transactions, so a pointer-only write followed by a
// repeated START and addr+R reads from the new pointer.
//
// Optional feature: define I2C_SLAVE_GLITCH_FILTER_EN to add a majority glitch
// filter on SCL and SDA (see i2c_line_cond).
//
// Parameters:
//   I2C_ADDR : 7-bit target address
//   NUM_REGS : register count, 2..256
//   PTR_W    : pointer width, derived from NUM_REGS
//
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   scl_i, sda_i    : pad inputs
//   sda_oe          : 1 pulls SDA low, 0 releases it
//   hst_we/hst_addr/hst_wdata : host write port
//   hst_rdata       : combinational regs[hst_addr]
//   i2c_wr_pulse    : one-cycle pulse per register written over I2C
//   i2c_wr_idx      : index of that write
//   busy            : high from START to STOP
`timescale 1ns/1ps

module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR = 7'h2A,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             hst_we,
    input  logic [PTR_W-1:0] hst_addr,
    input  logic [7:0]       hst_wdata,
    output logic [7:0]       hst_rdata,
    output logic             i2c_wr_pulse,
    output logic [PTR_W-1:0] i2c_wr_idx,
    output logic             busy
);

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_cond u_scl_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_i),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_cond u_sda_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    i2c_slv_state_e   state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ninth_q, ninth_d;   // 9th SCL rise seen in an ACK state
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_pulse_q;
    logic [PTR_W-1:0] wr_idx_q;
    logic [7:0]       regs_q [NUM_REGS];

    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;
    logic [PTR_W-1:0] ptr_inc;
    logic             ptr_ok;
    logic             hst_in_range;
    logic             i2c_we;

    // Byte as it stands once the current SCL rise has been sampled.
    assign rx_byte = {shift_q[6:0], sda_lvl};
    assign rd_byte = regs_q[ptr_q];
    assign ptr_inc = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_ok  = 32'(rx_byte) < NUM_REGS;

    // Only meaningful when NUM_REGS is not a power of two.
    assign hst_in_range = 32'(hst_addr) < NUM_REGS;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        ninth_d   = ninth_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        i2c_we    = 1'b0;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd7;
            ninth_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: begin
                end

                StAddr, StPtr, StWr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            ninth_d = 1'b0;
                            if (state_q == StAddr) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    state_d = StAddrAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StPtr) begin
                                // Out-of-range pointer is refused and not loaded.
                                if (ptr_ok) begin
                                    ptr_d   = PTR_W'(rx_byte);
                                    state_d = StPtrAck;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else begin
                                i2c_we  = 1'b1;
                                ptr_d   = ptr_inc;
                                state_d = StWrAck;
                            end
                        end
                    end
                end

                // Falling edge after the 8th bit: assert ACK. 9th rise: note it.
                // Falling edge after the 9th bit: release and move on.
                StAddrAck, StPtrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            sda_oe_d = drive_low(I2C_ACK);
                        end else begin
                            ninth_d   = 1'b0;
                            bit_cnt_d = 3'd7;
                            sda_oe_d  = 1'b0;
                            if (state_q == StAddrAck && rw_q == I2C_RW_READ) begin
                                state_d  = StRd;
                                shift_d  = rd_byte;
                                sda_oe_d = drive_low(rd_byte[7]);
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWr;
                            end
                        end
                    end else if (scl_rise) begin
                        ninth_d = 1'b1;
                    end
                end

                // MSB already on the bus on entry; each fall presents the next bit.
                StRd: begin
                    if (scl_fall) begin
                        sda_oe_d = drive_low(shift_q[6]);
                        shift_d  = {shift_q[6:0], shift_q[7]};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            ninth_d = 1'b0;
                            state_d = StRdAck;
                        end
                    end
                end

                StRdAck: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            // Hand SDA to the master for its ACK/NACK.
                            sda_oe_d = 1'b0;
                        end else begin
                            ninth_d   = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = StRd;
                            shift_d   = rd_byte;
                            sda_oe_d  = drive_low(rd_byte[7]);
                        end
                    end else if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = StIgnore;
                        end else begin
                            ptr_d   = ptr_inc;
                            ninth_d = 1'b1;
                        end
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd7;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            ninth_q    <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            ninth_q    <= ninth_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= i2c_we;
            if (i2c_we) begin
                wr_idx_q <= ptr_q;
            end
        end
    end

    // Register file; the I2C write is issued last so it wins an index clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: 8'h00};
        end else begin
            if (hst_we && hst_in_range) begin
                regs_q[hst_addr] <= hst_wdata;
            end
            if (i2c_we) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    assign hst_rdata    = hst_in_range ? regs_q[hst_addr] : 8'h00;
    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign i2c_wr_pulse = wr_pulse_q;
    assign i2c_wr_idx   = wr_idx_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-banged I2C master on an
// open-drain bus, scoreboard queues for ACK bits, read bytes and write pulses.
`timescale 1ns/1ps

module tb_i2c_slave_regfile;

    localparam int Q = 60;   // quarter SCL period in ns (clk period 10 ns)

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       m_scl     = 1'b1;
    logic       m_sda     = 1'b1;
    logic       hst_we    = 1'b0;
    logic [3:0] hst_addr  = 4'd0;
    logic [7:0] hst_wdata = 8'h00;
    logic       sda_oe;
    logic [7:0] hst_rdata;
    logic       i2c_wr_pulse;
    logic [3:0] i2c_wr_idx;
    logic       busy;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .I2C_ADDR (7'h2A),
        .NUM_REGS (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (m_scl),
        .sda_i        (sda_line),
        .sda_oe       (sda_oe),
        .hst_we       (hst_we),
        .hst_addr     (hst_addr),
        .hst_wdata    (hst_wdata),
        .hst_rdata    (hst_rdata),
        .i2c_wr_pulse (i2c_wr_pulse),
        .i2c_wr_idx   (i2c_wr_idx),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic       ack_q [$];
    logic [7:0] rd_q  [$];
    logic [3:0] wr_q  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write pulses are popped against the scoreboard as the DUT emits them.
    always @(negedge clk) begin
        if (rst_n && i2c_wr_pulse) begin
            chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) chk("wr_idx", 32'(i2c_wr_idx), 32'(wr_q.pop_front()));
        end
    end

    task automatic write_bit(input logic b);
        m_sda = b;
        #(Q);
        m_scl = 1'b1;
        #(2 * Q);
        m_scl = 1'b0;
        #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        #(Q);
        m_scl = 1'b1;
        #(Q);
        b = sda_line;
        #(Q);
        m_scl = 1'b0;
        #(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        #(Q);
        m_scl = 1'b1;
        #(Q);
        m_sda = 1'b0;
        #(Q);
        m_scl = 1'b0;
        #(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        #(Q);
        m_scl = 1'b1;
        #(Q);
        m_sda = 1'b1;
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic exp_ack);
        logic a;
        ack_q.push_back(exp_ack);
        for (int i = 0; i < 8; i++) write_bit(data[7-i]);
        read_bit(a);
        chk("ack_pending", 32'(ack_q.size() != 0), 32'd1);
        if (ack_q.size() != 0) chk($sformatf("ack_%02h", data), 32'(a), 32'(ack_q.pop_front()));
    endtask

    task automatic read_byte(input logic master_ack);
        logic [7:0] d;
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(master_ack);
        chk("rd_pending", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) chk("rd_data", 32'(d), 32'(rd_q.pop_front()));
    endtask

    task automatic host_write(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        hst_we    = 1'b1;
        hst_addr  = idx;
        hst_wdata = data;
        @(negedge clk);
        hst_we    = 1'b0;
    endtask

    task automatic reg_chk(input logic [3:0] idx, input logic [7:0] exp);
        @(negedge clk);
        hst_addr = idx;
        #1;
        chk($sformatf("reg%0d", idx), 32'(hst_rdata), 32'(exp));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_pulse", 32'(i2c_wr_pulse), 32'd0);
        chk("rst_wr_idx", 32'(i2c_wr_idx), 32'd0);
        reg_chk(4'd0, 8'h00);
        rst_n = 1'b1;
        #(Q);

        // Plain burst write at pointer 3
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h03, 1'b0);
        wr_q.push_back(4'd3);
        send_byte(8'hA5, 1'b0);
        wr_q.push_back(4'd4);
        send_byte(8'h5A, 1'b0);
        chk("busy_mid", 32'(busy), 32'd1);
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
        reg_chk(4'd3, 8'hA5);
        reg_chk(4'd4, 8'h5A);

        // Host writes, then pointer set + repeated START read of two bytes
        host_write(4'd7, 8'h3C);
        host_write(4'd8, 8'h81);
        reg_chk(4'd7, 8'h3C);
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h07, 1'b0);
        i2c_start();
        send_byte(8'h55, 1'b0);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'h81);
        read_byte(1'b0);
        read_byte(1'b1);
        chk("oe_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();

        // Address mismatch: nothing acknowledged, nothing written
        i2c_start();
        send_byte(8'h56, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        chk("busy_ignore", 32'(busy), 32'd1);
        i2c_stop();
        chk("busy_ignore_stop", 32'(busy), 32'd0);
        reg_chk(4'd1, 8'h00);

        // Out-of-range pointer is refused
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h10, 1'b1);
        send_byte(8'h99, 1'b1);
        i2c_stop();
        reg_chk(4'd0, 8'h00);
        reg_chk(4'd3, 8'hA5);

        // Burst wraps from the last register to 0
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h0F, 1'b0);
        wr_q.push_back(4'd15);
        send_byte(8'h11, 1'b0);
        wr_q.push_back(4'd0);
        send_byte(8'h22, 1'b0);
        wr_q.push_back(4'd1);
        send_byte(8'h33, 1'b0);
        i2c_stop();
        reg_chk(4'd15, 8'h11);
        reg_chk(4'd0, 8'h22);
        reg_chk(4'd1, 8'h33);

        // Reset while the target is driving an ACK
        i2c_start();
        send_byte(8'h54, 1'b0);
        for (int i = 0; i < 8; i++) write_bit(i == 6);   // pointer 0x02
        m_sda = 1'b1;
        #(Q);
        m_scl = 1'b1;
        #(Q / 2);
        chk("oe_ack_before_rst", 32'(sda_oe), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("oe_rst_async", 32'(sda_oe), 32'd0);
        chk("busy_rst_async", 32'(busy), 32'd0);
        reg_chk(4'd3, 8'h00);
        reg_chk(4'd15, 8'h00);
        m_scl = 1'b0;
        #(Q);
        m_scl = 1'b1;
        #(Q);
        rst_n = 1'b1;
        #(Q);

        // Normal write and read-back after reset
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h05, 1'b0);
        wr_q.push_back(4'd5);
        send_byte(8'hC3, 1'b0);
        i2c_stop();
        reg_chk(4'd5, 8'hC3);
        i2c_start();
        send_byte(8'h54, 1'b0);
        send_byte(8'h05, 1'b0);
        i2c_start();
        send_byte(8'h55, 1'b0);
        rd_q.push_back(8'hC3);
        read_byte(1'b1);
        i2c_stop();
        chk("busy_end", 32'(busy), 32'd0);

        repeat (4) @(negedge clk);
        chk("wr_left", 32'(wr_q.size()), 32'd0);
        chk("rd_left", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
